// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding, width defaults and requester ids for the memory arbiter
package mem_pkg;

    localparam int MEM_ADDR_W = 28;
    localparam int MEM_DATA_W = 128;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] GNT_I  = 3'd1;
    localparam logic [2:0] GNT_D  = 3'd2;
    localparam logic [2:0] RESP_I = 3'd3;
    localparam logic [2:0] RESP_D = 3'd4;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side block transfer signals of the arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_pkg::MEM_ADDR_W,
    parameter int DATA_W = mem_pkg::MEM_DATA_W
) ();
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker; the requester not served last wins a tie
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_id_i,
    output logic       grant_valid_o,
    output logic       grant_id_o
);
    logic last_q, last_d;

    assign last_d = upd_i ? upd_id_i : last_q;

    always_ff @(posedge clk) begin
        if (rst) last_q <= REQ_D;
        else     last_q <= last_d;
    end

    always_comb begin
        grant_valid_o = |req_i;
        grant_id_o    = &req_i ? ~last_q : (req_i[REQ_D] ? REQ_D : REQ_I);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block memory port between the I-cache and D-cache miss paths
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic [31:0]  i_grant_cnt,
    output logic [31:0]  d_grant_cnt,
    output logic         err
);
    localparam int              WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    logic [2:0]        state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [31:0]       i_cnt_q, i_cnt_d;
    logic [31:0]       d_cnt_q, d_cnt_d;
    logic              err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
    logic              gnt_valid, gnt_id, gnt_wr, done;

    assign wd_inc = wd_q + 1'b1;
    assign gnt_wr = (gnt_id == REQ_D) & bus.d_write;

    rr_arb2 u_rr (
        .clk          (clk),
        .rst          (rst),
        .req_i        ({bus.d_read | bus.d_write, bus.i_read}),
        .upd_i        (done),
        .upd_id_i     (state_q == GNT_D),
        .grant_valid_o(gnt_valid),
        .grant_id_o   (gnt_id)
    );

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_cnt_d     = i_cnt_q;
        d_cnt_d     = d_cnt_q;
        err_d       = err_q;
        wd_d        = wd_q;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.d_read && bus.d_write) err_d = 1'b1;
                if (gnt_valid) begin
                    state_d     = (gnt_id == REQ_D) ? GNT_D : GNT_I;
                    mem_addr_d  = (gnt_id == REQ_D) ? bus.d_addr : bus.i_addr;
                    mem_read_d  = ~gnt_wr;
                    mem_write_d = gnt_wr;
                    mem_wdata_d = gnt_wr ? bus.d_wdata : mem_wdata_q;
                    wd_d        = '0;
                end
            end
            GNT_I, GNT_D: begin
                if (bus.mem_ready) begin
                    done        = 1'b1;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = (state_q == GNT_I) ? RESP_I : RESP_D;
                    i_rdata_d   = (state_q == GNT_I) ? bus.mem_rdata : i_rdata_q;
                    d_rdata_d   = (state_q == GNT_D && mem_read_q) ? bus.mem_rdata : d_rdata_q;
                    i_cnt_d     = (state_q == GNT_I) ? i_cnt_q + 32'd1 : i_cnt_q;
                    d_cnt_d     = (state_q == GNT_D) ? d_cnt_q + 32'd1 : d_cnt_q;
                end else if (TIMEOUT > 0) begin
                    // saturate so the watchdog fires once per transaction and never wraps
                    wd_d  = (wd_q == WD_LIMIT) ? wd_q : wd_inc;
                    err_d = err_q | (wd_inc == WD_LIMIT);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_cnt_q     <= '0;
            d_cnt_q     <= '0;
            err_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_cnt_q     <= i_cnt_d;
            d_cnt_q     <= d_cnt_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ready   = (state_q == RESP_I);
    assign bus.d_ready   = (state_q == RESP_D);
    assign i_grant_cnt   = i_cnt_q;
    assign d_grant_cnt   = d_cnt_q;
    assign err           = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and a randomized scoreboard run
module tb_mem_arbiter;
    logic        clk;
    logic        rst;
    logic [31:0] icnt, dcnt;
    logic        err;
    int          n_chk = 0;
    int          n_pass = 0;

    mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) bus ();

    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .i_grant_cnt(icnt), .d_grant_cnt(dcnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL sim_timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        bit           i_rd, d_rd, d_wr;
        logic [27:0]  ia, da;
        logic [127:0] wd, rd;
        int           lat;
        bit           e_wr, e_i;
        logic [27:0]  e_addr;
        logic [127:0] e_rdata;
        int unsigned  e_icnt, e_dcnt;
        bit           e_err;
    } vec_t;

    localparam logic [127:0] R0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] R1 = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF;
    localparam logic [127:0] R2 = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
    localparam logic [127:0] R3 = 128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] R4 = 128'hCAFEBABE_FEEDFACE_BAADF00D_0BADC0DE;
    localparam logic [127:0] R5 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] R6 = 128'h76543210_FEDCBA98_DEADC0DE_00C0FFEE;
    localparam logic [127:0] WB = 128'hDEADBEEF_00000000_00000000_00000001;
    localparam logic [127:0] W3 = 128'h33333333_33333333_33333333_33333333;
    localparam logic [127:0] W5 = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;

    // bench-side scoreboard for the randomized run
    int           ph, own, lat;
    bit           last_srv, exp_wr;
    logic [27:0]  exp_addr;
    logic [127:0] exp_wd, m_irdata, m_drdata;
    int unsigned  m_icnt, m_dcnt;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        bus.i_read = 0; bus.i_addr = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        step();
        step();
        rst = 0;
    endtask

    task automatic rnd_cycle();
        step();
        case (ph)
            0: if (bus.i_read || bus.d_read || bus.d_write) begin
                own = (bus.i_read && (bus.d_read || bus.d_write)) ? int'(!last_srv) : (bus.i_read ? 0 : 1);
                exp_wr = (own == 1) && bus.d_write;
                exp_addr = (own == 1) ? bus.d_addr : bus.i_addr;
                if (exp_wr) exp_wd = bus.d_wdata;
                lat = $urandom_range(0, 6);
                ph = 1;
            end
            1: if (bus.mem_ready) begin
                if (own == 0) begin m_irdata = bus.mem_rdata; m_icnt++; end
                else begin if (!exp_wr) m_drdata = bus.mem_rdata; m_dcnt++; end
                last_srv = (own == 1);
                ph = 2;
            end
            default: ph = 0;
        endcase
        chk("rnd_mem_read", bus.mem_read, ph == 1 && !exp_wr);
        chk("rnd_mem_write", bus.mem_write, ph == 1 && exp_wr);
        if (ph == 1) chk("rnd_mem_addr", bus.mem_addr, exp_addr);
        if (ph == 1 && exp_wr) chk("rnd_mem_wdata", bus.mem_wdata, exp_wd);
        chk("rnd_i_ready", bus.i_ready, ph == 2 && own == 0);
        chk("rnd_d_ready", bus.d_ready, ph == 2 && own == 1);
        chk("rnd_i_rdata", bus.i_rdata, m_irdata);
        chk("rnd_d_rdata", bus.d_rdata, m_drdata);
        chk("rnd_i_cnt", icnt, m_icnt);
        chk("rnd_d_cnt", dcnt, m_dcnt);
        chk("rnd_err", err, 0);
        bus.mem_rdata = rnd128();
        if (ph == 1) begin
            bus.mem_ready = (lat == 0);
            if (lat > 0) lat--;
        end else bus.mem_ready = ($urandom_range(0, 7) == 0);
        if (ph == 2 && own == 0) bus.i_read = 0;
        else if (!bus.i_read && $urandom_range(0, 2) == 0) begin
            bus.i_read = 1; bus.i_addr = 28'($urandom);
        end
        if (ph == 2 && own == 1) begin bus.d_read = 0; bus.d_write = 0; end
        else if (!bus.d_read && !bus.d_write && $urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 1) bus.d_write = 1; else bus.d_read = 1;
            bus.d_addr = 28'($urandom); bus.d_wdata = rnd128();
        end
    endtask

    initial begin
        vec_t vt[7];
        bit   seen;
        vt[0] = '{1, 0, 0, 28'h0000010, 28'h0000055, 128'h0, R0, 5, 0, 1, 28'h0000010, R0, 1, 0, 0};
        vt[1] = '{1, 1, 0, 28'h0000020, 28'h0000030, 128'h0, R1, 2, 0, 0, 28'h0000030, R1, 1, 1, 0};
        vt[2] = '{0, 0, 1, 28'h0000000, 28'h00000A3, WB,     R2, 8, 1, 0, 28'h00000A3, R1, 1, 2, 0};
        vt[3] = '{1, 0, 1, 28'h0000040, 28'h0000050, W3,     R3, 0, 0, 1, 28'h0000040, R3, 2, 2, 0};
        vt[4] = '{1, 1, 0, 28'h0000060, 28'h0000070, 128'h0, R4, 1, 0, 0, 28'h0000070, R4, 2, 3, 0};
        vt[5] = '{0, 1, 1, 28'h0000000, 28'h0000080, W5,     R5, 3, 1, 0, 28'h0000080, R4, 2, 4, 1};
        vt[6] = '{1, 0, 0, 28'h0000090, 28'h0000000, 128'h0, R6, 2, 0, 1, 28'h0000090, R6, 3, 4, 1};

        do_reset();
        chk("rst_strobes", {bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready}, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        chk("rst_cnt_err", {icnt, dcnt, err}, 0);

        for (int v = 0; v < 7; v++) begin
            bus.i_read = vt[v].i_rd; bus.d_read = vt[v].d_rd; bus.d_write = vt[v].d_wr;
            bus.i_addr = vt[v].ia; bus.d_addr = vt[v].da; bus.d_wdata = vt[v].wd;
            step();
            chk($sformatf("v%0d_mem_read", v), bus.mem_read, !vt[v].e_wr);
            chk($sformatf("v%0d_mem_write", v), bus.mem_write, vt[v].e_wr);
            chk($sformatf("v%0d_mem_addr", v), bus.mem_addr, vt[v].e_addr);
            if (vt[v].e_wr) chk($sformatf("v%0d_mem_wdata", v), bus.mem_wdata, vt[v].wd);
            for (int k = 0; k < vt[v].lat; k++) begin
                bus.i_addr = 28'($urandom); bus.d_addr = 28'($urandom);
                bus.d_wdata = rnd128(); bus.mem_rdata = rnd128();
                step();
                chk($sformatf("v%0d_hold_bus", v), {bus.mem_read, bus.mem_write, bus.mem_addr},
                    {!vt[v].e_wr, vt[v].e_wr, vt[v].e_addr});
                if (vt[v].e_wr) chk($sformatf("v%0d_hold_wdata", v), bus.mem_wdata, vt[v].wd);
                chk($sformatf("v%0d_wait_ready", v), {bus.i_ready, bus.d_ready}, 0);
            end
            bus.mem_ready = 1; bus.mem_rdata = vt[v].rd;
            step();
            chk($sformatf("v%0d_ready", v), {bus.i_ready, bus.d_ready}, {vt[v].e_i, !vt[v].e_i});
            chk($sformatf("v%0d_rdata", v), vt[v].e_i ? bus.i_rdata : bus.d_rdata, vt[v].e_rdata);
            chk($sformatf("v%0d_strobe_off", v), {bus.mem_read, bus.mem_write}, 0);
            chk($sformatf("v%0d_cnts", v), {icnt, dcnt}, {vt[v].e_icnt, vt[v].e_dcnt});
            chk($sformatf("v%0d_err", v), err, vt[v].e_err);
            bus.mem_ready = 0; bus.i_read = 0; bus.d_read = 0; bus.d_write = 0;
            step();
            chk($sformatf("v%0d_ready_once", v), {bus.i_ready, bus.d_ready}, 0);
        end

        // both caches hold requests continuously: grants must alternate starting with I
        do_reset();
        bus.i_read = 1; bus.d_read = 1; bus.i_addr = 28'h111; bus.d_addr = 28'h222;
        for (int g = 0; g < 4; g++) begin
            seen = 0;
            for (int k = 0; k < 20; k++) begin
                if (bus.mem_read) begin seen = 1; break; end
                step();
            end
            chk("rr_strobe_seen", seen, 1);
            if (!seen) break;
            chk($sformatf("rr_grant%0d", g), bus.mem_addr, (g % 2 == 1) ? 28'h222 : 28'h111);
            bus.mem_ready = 1; bus.mem_rdata = rnd128();
            step();
            bus.mem_ready = 0;
            if (bus.d_ready) bus.d_read = 0;
            if (bus.i_ready) bus.i_read = 0;
            step();
            bus.i_read = 1; bus.d_read = 1;
        end
        bus.i_read = 0; bus.d_read = 0;
        step();
        step();

        // watchdog: memory stalls, err rises on the 16th wait cycle, late ready still completes
        do_reset();
        bus.i_read = 1; bus.i_addr = 28'h5;
        step();
        chk("to_strobe", bus.mem_read, 1);
        repeat (15) step();
        chk("to_err_before", err, 0);
        step();
        chk("to_err_at16", err, 1);
        repeat (4) step();
        chk("to_still_waiting", {bus.mem_read, bus.i_ready}, 2'b10);
        bus.mem_ready = 1; bus.mem_rdata = R3;
        step();
        chk("to_late_ready", bus.i_ready, 1);
        chk("to_late_rdata", bus.i_rdata, R3);
        chk("to_late_cnt_err", {icnt, err}, {32'd1, 1'b1});
        bus.mem_ready = 0; bus.i_read = 0;
        step();

        // reset while a D read is outstanding abandons it cleanly
        bus.d_read = 1; bus.d_addr = 28'h77;
        step();
        chk("rstmid_strobe", bus.mem_read, 1);
        step();
        rst = 1;
        step();
        rst = 0; bus.d_read = 0; bus.mem_ready = 1;
        chk("rstmid_strobe_off", {bus.mem_read, bus.d_ready}, 0);
        chk("rstmid_cnt_err", {icnt, dcnt, err}, 0);
        step();
        chk("rstmid_no_ready", {bus.i_ready, bus.d_ready, bus.mem_read}, 0);
        bus.mem_ready = 0; bus.i_read = 1; bus.i_addr = 28'h99;
        step();
        chk("rstmid_regrant", {bus.mem_read, bus.mem_addr}, {1'b1, 28'h99});
        bus.mem_ready = 1; bus.mem_rdata = R5;
        step();
        chk("rstmid_complete", {bus.i_ready, icnt}, {1'b1, 32'd1});
        bus.mem_ready = 0; bus.i_read = 0;
        step();

        do_reset();
        ph = 0; own = 0; lat = 0; last_srv = 1; exp_wr = 0; exp_addr = '0; exp_wd = '0;
        m_irdata = '0; m_drdata = '0; m_icnt = 0; m_dcnt = 0;
        for (int c = 0; c < 2000; c++) rnd_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
